// File: rtl/dsp_pkg.sv
// Shared types and constant helpers for the sparse MAC group.
package dsp_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

  // Widest accumulator the constant helpers below can describe.
  localparam int MAX_W = 128;

  // Slot-select width: at least one bit, even for a single candidate.
  function automatic int idx_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  // All-ones value of width w (unsigned maximum).
  function automatic logic [MAX_W-1:0] umax(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  // Largest positive two's-complement value of width w.
  function automatic logic [MAX_W-1:0] smax(input int w);
    return umax(w) >> 1;
  endfunction

  // Most negative two's-complement value of width w.
  function automatic logic [MAX_W-1:0] smin(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/sparse_mac_lane.sv
// One multiply lane: picks 1 of SPARSE_M activations and multiplies it by the
// lane weight, signed or unsigned, with a registered product and valid bit.
module sparse_mac_lane
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SPARSE_M   = 2,
  localparam int IDX_W     = idx_w(SPARSE_M)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         sgn,
  input  logic [SPARSE_M*DATA_WIDTH-1:0] act,
  input  logic [DATA_WIDTH-1:0]        wgt,
  input  logic [IDX_W-1:0]             idx,
  output logic [2*DATA_WIDTH-1:0]      product,
  output logic                         p_valid
);

  logic [DATA_WIDTH-1:0]   sel;
  logic [2*DATA_WIDTH-1:0] act_ext;
  logic [2*DATA_WIDTH-1:0] wgt_ext;
  logic [2*DATA_WIDTH-1:0] prod;

  // Slot mux; an index past the last slot selects zero. Operands are
  // extended to the product width so one multiplier serves both modes.
  always_comb begin
    sel = '0;
    for (int s = 0; s < SPARSE_M; s++) begin
      if (idx == IDX_W'(s)) sel = act[s*DATA_WIDTH +: DATA_WIDTH];
    end
    act_ext = sgn ? {{DATA_WIDTH{sel[DATA_WIDTH-1]}}, sel} : {{DATA_WIDTH{1'b0}}, sel};
    wgt_ext = sgn ? {{DATA_WIDTH{wgt[DATA_WIDTH-1]}}, wgt} : {{DATA_WIDTH{1'b0}}, wgt};
    prod    = act_ext * wgt_ext;
  end

  // Stage-1 register: capture the product of each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      p_valid <= 1'b0;
    end else begin
      p_valid <= in_valid;
      if (in_valid) product <= prod;
    end
  end

endmodule

// File: rtl/sparse_mac_group.sv
// LANES sparse-select multipliers feeding an adder tree and a multi-beat
// accumulator seeded from cascade_in, with saturating or wrapping overflow.
module sparse_mac_group
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 48,
  parameter int LANES       = 4,
  parameter int SPARSE_M    = 2,
  parameter int LEN_WIDTH   = 8,
  parameter int LSP_WIDTH   = 24,
  parameter int SATURATE    = 1,
  localparam int IDX_W      = idx_w(SPARSE_M)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [LEN_WIDTH-1:0]                cfg_len,
  input  logic                                cfg_signed,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*SPARSE_M*DATA_WIDTH-1:0] act_in,
  input  logic [LANES*DATA_WIDTH-1:0]         wgt_in,
  input  logic [LANES*IDX_W-1:0]              sparse_idx,
  input  logic [ACCUM_WIDTH-1:0]              cascade_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ACCUM_WIDTH-1:0]              out_data,
  output logic [ACCUM_WIDTH-LSP_WIDTH-1:0]    out_msp,
  output logic [LSP_WIDTH-1:0]                out_lsp,
  output logic                                overflow,
  output logic [ACCUM_WIDTH-1:0]              cascade_out
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int TREE_W = ACCUM_WIDTH + $clog2(LANES);
  localparam int SUM_W  = TREE_W + 1;

  localparam logic [MAX_W-1:0] UMAX_F = umax(ACCUM_WIDTH);
  localparam logic [MAX_W-1:0] SMAX_F = smax(ACCUM_WIDTH);
  localparam logic [MAX_W-1:0] SMIN_F = smin(ACCUM_WIDTH);
  localparam logic [ACCUM_WIDTH-1:0] ACC_UMAX = UMAX_F[ACCUM_WIDTH-1:0];
  localparam logic [ACCUM_WIDTH-1:0] ACC_SMAX = SMAX_F[ACCUM_WIDTH-1:0];
  localparam logic [ACCUM_WIDTH-1:0] ACC_SMIN = SMIN_F[ACCUM_WIDTH-1:0];

  state_t                   state_reg;
  logic [LEN_WIDTH-1:0]     len_reg;
  logic [LEN_WIDTH-1:0]     count_reg;
  logic                     signed_reg;
  logic [ACCUM_WIDTH-1:0]   acc_reg;
  logic                     ovf_reg;
  logic                     out_valid_reg;
  logic                     in_ready_reg;

  logic                     fire;
  logic                     first_beat;
  logic                     lane_signed;
  logic [LEN_WIDTH-1:0]     len_first;
  logic [LEN_WIDTH-1:0]     count_inc;
  logic [LANES-1:0]         lane_valid;
  logic                     p_valid;
  logic [PROD_W-1:0]        products [LANES];
  logic [TREE_W-1:0]        prod_ext [LANES];
  logic [TREE_W-1:0]        lane_sum;
  logic [SUM_W-1:0]         total;
  logic [SUM_W-ACCUM_WIDTH:0] total_hi;
  logic                     ovf_now;
  logic [ACCUM_WIDTH-1:0]   acc_next;

  assign fire        = in_valid && in_ready_reg;
  assign first_beat  = (state_reg == IDLE) && fire;
  // The first beat multiplies before cfg_signed is latched, so use it live.
  assign lane_signed = (state_reg == IDLE) ? cfg_signed : signed_reg;
  assign len_first   = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
  assign count_inc   = count_reg + 1'b1;
  assign p_valid     = &lane_valid;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sparse_mac_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .SPARSE_M  (SPARSE_M)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .in_valid(fire),
        .sgn     (lane_signed),
        .act     (act_in[gi*SPARSE_M*DATA_WIDTH +: SPARSE_M*DATA_WIDTH]),
        .wgt     (wgt_in[gi*DATA_WIDTH +: DATA_WIDTH]),
        .idx     (sparse_idx[gi*IDX_W +: IDX_W]),
        .product (products[gi]),
        .p_valid (lane_valid[gi])
      );
      assign prod_ext[gi] = signed_reg ?
        {{(TREE_W-PROD_W){products[gi][PROD_W-1]}}, products[gi]} :
        {{(TREE_W-PROD_W){1'b0}}, products[gi]};
    end
  endgenerate

  // Adder tree plus accumulate in a widened domain; any result outside the
  // ACCUM_WIDTH range (including tree growth) is flagged and clamped or wrapped.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + prod_ext[l];
    total = (signed_reg ? {{(SUM_W-ACCUM_WIDTH){acc_reg[ACCUM_WIDTH-1]}}, acc_reg}
                        : {{(SUM_W-ACCUM_WIDTH){1'b0}}, acc_reg})
          + (signed_reg ? {lane_sum[TREE_W-1], lane_sum} : {1'b0, lane_sum});
    total_hi = total[SUM_W-1:ACCUM_WIDTH-1];
    acc_next = total[ACCUM_WIDTH-1:0];
    if (signed_reg) begin
      ovf_now = !((total_hi == '0) || (&total_hi));
      if (ovf_now && SATURATE != 0) acc_next = total[SUM_W-1] ? ACC_SMIN : ACC_SMAX;
    end else begin
      ovf_now = |total[SUM_W-1:ACCUM_WIDTH];
      if (ovf_now && SATURATE != 0) acc_next = ACC_UMAX;
    end
  end

  // Control FSM: beat counting, config latch and registered handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      count_reg     <= '0;
      signed_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      unique case (state_reg)
        IDLE: if (fire) begin
          len_reg    <= len_first;
          signed_reg <= cfg_signed;
          count_reg  <= LEN_WIDTH'(1);
          if (len_first == LEN_WIDTH'(1)) begin
            state_reg    <= FLUSH;
            in_ready_reg <= 1'b0;
          end else begin
            state_reg <= ACCUM;
          end
        end
        ACCUM: if (fire) begin
          count_reg <= count_inc;
          if (count_inc == len_reg) begin
            state_reg    <= FLUSH;
            in_ready_reg <= 1'b0;
          end
        end
        FLUSH: begin
          state_reg     <= HOLD;
          out_valid_reg <= 1'b1;
        end
        HOLD: if (out_ready) begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Accumulator and sticky overflow: seed on the first beat, add each product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (first_beat) begin
      acc_reg <= cascade_in;
      ovf_reg <= 1'b0;
    end else if (p_valid) begin
      acc_reg <= acc_next;
      ovf_reg <= ovf_reg | ovf_now;
    end else if (state_reg == HOLD && out_ready) begin
      ovf_reg <= 1'b0;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = acc_reg;
  assign out_msp     = acc_reg[ACCUM_WIDTH-1:LSP_WIDTH];
  assign out_lsp     = acc_reg[LSP_WIDTH-1:0];
  assign overflow    = ovf_reg;
  assign cascade_out = acc_reg;

endmodule

// File: tb/tb_sparse_mac_group.sv
// Directed bench: a saturating and a wrapping instance share stimulus; a
// scoreboard queue holds expected results pushed when each operation starts.
module tb_sparse_mac_group;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_len;
  logic        cfg_signed;
  logic        in_valid;
  logic [63:0] act_in;
  logic [31:0] wgt_in;
  logic [3:0]  sparse_idx;
  logic [47:0] cascade_in;
  logic        out_ready;

  logic        in_ready, out_valid, overflow;
  logic [47:0] out_data, cascade_out;
  logic [23:0] out_msp, out_lsp;

  logic        in_ready_w, out_valid_w, overflow_w;
  logic [47:0] out_data_w, cascade_out_w;
  logic [23:0] out_msp_w, out_lsp_w;

  typedef struct {
    logic [47:0] d_sat;
    logic [47:0] d_wrap;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sparse_mac_group #(.SATURATE(1)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wgt_in(wgt_in),
    .sparse_idx(sparse_idx), .cascade_in(cascade_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_msp(out_msp),
    .out_lsp(out_lsp), .overflow(overflow), .cascade_out(cascade_out)
  );

  sparse_mac_group #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .in_ready(in_ready_w), .act_in(act_in), .wgt_in(wgt_in),
    .sparse_idx(sparse_idx), .cascade_in(cascade_in), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_data(out_data_w), .out_msp(out_msp_w),
    .out_lsp(out_lsp_w), .overflow(overflow_w), .cascade_out(cascade_out_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [47:0] d_sat, input logic [47:0] d_wrap, input logic ovf);
    exp_t e;
    e.d_sat = d_sat; e.d_wrap = d_wrap; e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Drive one beat with full vectors and wait (bounded) for its acceptance.
  task automatic beat_raw(input logic [63:0] a, input logic [31:0] w, input logic [3:0] idx,
                          input logic [7:0] len, input logic sgn, input logic [47:0] casc);
    int waited = 0;
    act_in = a; wgt_in = w; sparse_idx = idx;
    cfg_len = len; cfg_signed = sgn; cascade_in = casc;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("beat_accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Same operands on every lane.
  task automatic beat(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] w,
                      input logic idx, input logic [7:0] len, input logic sgn,
                      input logic [47:0] casc);
    logic [63:0] a;
    logic [31:0] wv;
    for (int l = 0; l < 4; l++) begin
      a[(l*2)*8 +: 8]   = a0;
      a[(l*2+1)*8 +: 8] = a1;
      wv[l*8 +: 8]      = w;
    end
    beat_raw(a, wv, {4{idx}}, len, sgn, casc);
  endtask

  // Wait (bounded) for a result, compare against the scoreboard, handshake.
  task automatic collect(input string tag);
    int waited = 0;
    exp_t e;
    out_ready = 1'b1;
    while (!out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!out_valid) begin
      check({tag, "_valid_timeout"}, {63'd0, out_valid}, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected_result"}, 64'd1, 64'd0 + sb.size());
      return;
    end
    e = sb.pop_front();
    $display("[TB] result %s out_data=%h wrap=%h overflow=%0b", tag, out_data, out_data_w, overflow);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, e.d_sat});
    check({tag, "_data_wrap"}, {16'd0, out_data_w}, {16'd0, e.d_wrap});
    check({tag, "_split"}, {16'd0, out_msp, out_lsp}, {16'd0, e.d_sat});
    check({tag, "_cascade"}, {16'd0, cascade_out}, {16'd0, e.d_sat});
    check({tag, "_ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
    check({tag, "_ovf_wrap"}, {63'd0, overflow_w}, {63'd0, e.ovf});
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_ovf_clear"}, {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [31:0] w;
    rst = 1'b1; cfg_len = '0; cfg_signed = 1'b0; in_valid = 1'b0;
    act_in = '0; wgt_in = '0; sparse_idx = '0; cascade_in = '0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", {16'd0, out_data}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Unsigned dot product over 3 beats: 4 lanes * 2*3 * 3 beats = 72.
    push(48'd72, 48'd72, 1'b0);
    repeat (3) beat(8'd2, 8'd9, 8'd3, 1'b0, 8'd3, 1'b0, 48'd0);
    check("lat_flush_no_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_valid_2nd_edge", {63'd0, out_valid}, 64'd1);
    collect("unsigned_len3");

    // Sparse slot select: slot 1 -> 4*5*2+10 = 50, slot 0 -> 4*1*2+10 = 18.
    push(48'd50, 48'd50, 1'b0);
    beat(8'd1, 8'd5, 8'd2, 1'b1, 8'd1, 1'b0, 48'd10);
    collect("sparse_idx1");
    push(48'd18, 48'd18, 1'b0);
    beat(8'd1, 8'd5, 8'd2, 1'b0, 8'd0, 1'b0, 48'd10);   // len 0 behaves as 1
    collect("sparse_idx0_len0");

    // Signed: 4 * (-128*127) + 100 = -64924.
    push(48'hFFFF_FFFF_0264, 48'hFFFF_FFFF_0264, 1'b0);
    beat(8'h80, 8'h00, 8'h7F, 1'b0, 8'd1, 1'b1, 48'd100);
    collect("signed_neg");

    // Signed overflow from +max by +1: clamp to +max, or wrap to -2^47.
    a = '0; w = '0; a[7:0] = 8'd1; w[7:0] = 8'd1;
    push(48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 1'b1);
    beat_raw(a, w, 4'd0, 8'd1, 1'b1, 48'h7FFF_FFFF_FFFF);
    collect("signed_ovf");

    // Unsigned carry-out: clamp to all-ones, or wrap to 0.
    push(48'hFFFF_FFFF_FFFF, 48'd0, 1'b1);
    beat_raw(a, w, 4'd0, 8'd1, 1'b0, 48'hFFFF_FFFF_FFFF);
    collect("unsigned_ovf");

    // len=4 with 2-cycle bubbles; cfg changes after beat 1 are ignored, so the
    // 200 stays unsigned: 4*(1+2+3+200) + 5 = 829. Output is then backpressured.
    push(48'd829, 48'd829, 1'b0);
    out_ready = 1'b0;
    beat(8'd1, 8'd0, 8'd1, 1'b0, 8'd4, 1'b0, 48'd5);
    for (int b = 2; b <= 4; b++) begin
      repeat (2) begin @(posedge clk); #1; end
      beat((b == 4) ? 8'd200 : 8'(b), 8'd0, 8'd1, 1'b0, 8'd1, 1'b1, 48'd999);
    end
    @(posedge clk); #1;
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_data", {16'd0, out_data}, {16'd0, sb[0].d_sat});
      check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    collect("bubbles_backpressure");

    // Reset after 2 of 4 beats; the partial result must never appear.
    beat(8'd5, 8'd0, 8'd5, 1'b0, 8'd4, 1'b0, 48'd7);
    beat(8'd5, 8'd0, 8'd5, 1'b0, 8'd4, 1'b0, 48'd7);
    rst = 1'b1;
    #1;
    check("midrst_out_data", {16'd0, out_data}, 64'd0);
    check("midrst_cascade_out", {16'd0, cascade_out}, 64'd0);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_overflow", {63'd0, overflow}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    // Fresh op: 4*3*3 + 7 = 43.
    push(48'd43, 48'd43, 1'b0);
    beat(8'd3, 8'd0, 8'd3, 1'b0, 8'd1, 1'b0, 48'd7);
    collect("after_reset");

    check("scoreboard_drained", 64'd0 + sb.size(), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
